stream_rr_arb: RTL and testbench

- Parametrised packet-aware stream arbiter; successor to the combinational fixed-priority arbiter.
- Sits at each StreamXBar output port and selects one of NUM_REQUEST input streams.
- Modes: round-robin (rotating priority) or fixed priority.
- Holds the grant for a whole packet, from first beat until the beat with last set is accepted.

---
 rtl/stream_arb_pkg.sv | 27 ++
 rtl/fixed_prio_arb.sv | 14 +
 rtl/stream_rr_arb.sv | 130 +++++++++++++
 tb/tb_stream_rr_arb.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-aware stream arbiter.
//   arb_mode_e    : arbitration policy selector (round-robin or fixed priority)
//   onehot_to_idx : binary index of the set bit in a one-hot vector (0 when empty)
package stream_arb_pkg;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_e;

    // Widest request vector the index helper accepts.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_REQ);

    // OR-reduction encoder: exact for one-hot inputs, 0 for an all-zero vector.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority arbiter: grants the lowest-indexed active request.
//   req_i : request vector
//   gnt_o : one-hot grant, all-zero when no request is active
module fixed_prio_arb #(
    parameter int unsigned NUM_REQUEST = 4
) (
    input  logic [NUM_REQUEST-1:0] req_i,
    output logic [NUM_REQUEST-1:0] gnt_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + NUM_REQUEST'(1));

endmodule

// File: rtl/stream_rr_arb.sv
// Packet-aware stream arbiter with round-robin or fixed-priority selection.
// Once a beat without last is accepted, the grant is held on that input until
// its last beat is accepted.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   request_i     : per-input valid
//   last_i        : per-input last-beat flag
//   ready_i       : downstream ready for the granted stream
//   grant_o       : one-hot grant (all-zero when idle or in reset)
//   grant_idx_o   : binary index of grant_o, 0 when no grant
//   valid_o       : granted input is presenting a beat
//   locked_o      : arbiter is in the middle of a packet
module stream_rr_arb
    import stream_arb_pkg::*;
#(
    parameter int unsigned NUM_REQUEST = 4,
    parameter arb_mode_e   ARB_MODE    = ARB_RR,
    localparam int unsigned IDX_W      = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQUEST-1:0] request_i,
    input  logic [NUM_REQUEST-1:0] last_i,
    input  logic                   ready_i,
    output logic [NUM_REQUEST-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   valid_o,
    output logic                   locked_o
);

    logic                   lock_q, lock_d;
    logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [NUM_REQUEST-1:0] mask_c;
    logic [NUM_REQUEST-1:0] req_masked_c;
    logic [NUM_REQUEST-1:0] gnt_masked_c;
    logic [NUM_REQUEST-1:0] gnt_unmasked_c;
    logic [NUM_REQUEST-1:0] arb_gnt_c;
    logic [NUM_REQUEST-1:0] grant_c;
    logic [IDX_W-1:0]       grant_idx_c;
    logic                   valid_c;
    logic                   sel_last_c;
    logic                   hs_c;

    // Keep only requests at or above the rotating pointer.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
            mask_c[i] = (IDX_W'(i) >= ptr_q);
        end
    end

    assign req_masked_c = request_i & mask_c;

    fixed_prio_arb #(
        .NUM_REQUEST (NUM_REQUEST)
    ) u_arb_masked (
        .req_i (req_masked_c),
        .gnt_o (gnt_masked_c)
    );

    fixed_prio_arb #(
        .NUM_REQUEST (NUM_REQUEST)
    ) u_arb_unmasked (
        .req_i (request_i),
        .gnt_o (gnt_unmasked_c)
    );

    // Fall back to the unmasked winner when nothing sits above the pointer.
    always_comb begin
        arb_gnt_c = gnt_unmasked_c;
        if ((ARB_MODE == ARB_RR) && (|req_masked_c)) begin
            arb_gnt_c = gnt_masked_c;
        end
    end

    // Reset blanks the grant; a held packet overrides arbitration.
    always_comb begin
        grant_c = '0;
        if (!rst_ni) begin
            grant_c = '0;
        end else if (lock_q) begin
            grant_c = NUM_REQUEST'(1) << lock_idx_q;
        end else begin
            grant_c = arb_gnt_c;
        end
    end

    assign grant_idx_c = IDX_W'(onehot_to_idx(MAX_REQ'(grant_c)));
    assign valid_c     = |(grant_c & request_i);
    assign sel_last_c  = |(grant_c & last_i);
    assign hs_c        = valid_c & ready_i;

    // Next-state: lock on a non-last beat, release and rotate on the last beat.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (hs_c) begin
            if (sel_last_c) begin
                lock_d = 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    ptr_d = (grant_idx_c == IDX_W'(NUM_REQUEST - 1)) ? '0
                                                                     : grant_idx_c + IDX_W'(1);
                end
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = grant_idx_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            ptr_q      <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
        end
    end

    assign grant_o     = grant_c;
    assign grant_idx_o = grant_idx_c;
    assign valid_o     = valid_c;
    assign locked_o    = lock_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Self-checking bench: one round-robin and one fixed-priority arbiter share the
// stimulus; each is compared every cycle against a packet-level reference model.
module tb_stream_rr_arb;
    import stream_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = 4'b0;
    logic [3:0] last = 4'b0;
    logic       ready = 1'b0;

    logic [3:0] gr_rr, gr_fx;
    logic [1:0] gi_rr, gi_fx;
    logic       v_rr, v_fx, l_rr, l_fx;

    int errors = 0;
    int checks = 0;

    // Reference model state: [0] = round-robin, [1] = fixed priority.
    bit m_lock [2];
    int m_idx  [2];
    int m_ptr  [2];

    always #5 clk = ~clk;

    stream_rr_arb #(.NUM_REQUEST(4), .ARB_MODE(ARB_RR)) dut_rr (
        .clk_i (clk), .rst_ni (rst_n), .request_i (request), .last_i (last),
        .ready_i (ready), .grant_o (gr_rr), .grant_idx_o (gi_rr),
        .valid_o (v_rr), .locked_o (l_rr)
    );

    stream_rr_arb #(.NUM_REQUEST(4), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_i (clk), .rst_ni (rst_n), .request_i (request), .last_i (last),
        .ready_i (ready), .grant_o (gr_fx), .grant_idx_o (gi_fx),
        .valid_o (v_fx), .locked_o (l_fx)
    );

    // Winner: held input while mid-packet, otherwise first active request
    // scanning upward (with wrap) from the priority pointer.
    function automatic int pick(input int m);
        int start;
        if (m_lock[m]) return m_idx[m];
        start = (m == 0) ? m_ptr[m] : 0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (request[j]) return j;
        end
        return -1;
    endfunction

    task automatic check_mode(input int m, input logic [3:0] g, input logic [1:0] gi,
                              input logic v, input logic l);
        int         w;
        logic [3:0] eg;
        logic [1:0] egi;
        logic       ev;
        string      tag;
        tag = (m == 0) ? "rr" : "fx";
        w   = pick(m);
        eg  = (rst_n && w >= 0) ? 4'(1 << w) : 4'b0;
        egi = (rst_n && w >= 0) ? 2'(w) : 2'd0;
        ev  = rst_n && (w >= 0) && request[w];

        checks++;
        assert (g === eg) else begin
            errors++;
            $error("FAIL %s.grant observed=%b expected=%b t=%0t", tag, g, eg, $time);
        end
        checks++;
        assert (gi === egi) else begin
            errors++;
            $error("FAIL %s.grant_idx observed=%0d expected=%0d t=%0t", tag, gi, egi, $time);
        end
        checks++;
        assert (v === ev) else begin
            errors++;
            $error("FAIL %s.valid observed=%b expected=%b t=%0t", tag, v, ev, $time);
        end
        checks++;
        assert (l === m_lock[m]) else begin
            errors++;
            $error("FAIL %s.locked observed=%b expected=%b t=%0t", tag, l, m_lock[m], $time);
        end

        // Advance the model across the coming clock edge.
        if (!rst_n) begin
            m_lock[m] = 1'b0;
            m_idx[m]  = 0;
            m_ptr[m]  = 0;
        end else if (ev && ready) begin
            if (last[w]) begin
                m_lock[m] = 1'b0;
                if (m == 0) m_ptr[m] = (w + 1) % 4;
            end else begin
                m_lock[m] = 1'b1;
                m_idx[m]  = w;
            end
        end
    endtask

    // One clock: drive after the edge, compare on the falling edge.
    task automatic cyc(input logic rn, input logic [3:0] req, input logic [3:0] lst,
                       input logic rdy);
        @(posedge clk);
        #1;
        rst_n   = rn;
        request = req;
        last    = lst;
        ready   = rdy;
        @(negedge clk);
        check_mode(0, gr_rr, gi_rr, v_rr, l_rr);
        check_mode(1, gr_fx, gi_fx, v_fx, l_fx);
    endtask

    // Directed literal check of a grant vector against a hand-derived value.
    task automatic lit(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [3:0] rr_seq [5];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int m = 0; m < 2; m++) begin
            m_lock[m] = 1'b0;
            m_idx[m]  = 0;
            m_ptr[m]  = 0;
        end

        // Reset state.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1111, 4'b0000, 1'b1);
        lit("reset_grant", gr_rr, 4'b0000);

        // Round-robin rotation with single-beat packets.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'b1111, 4'b1111, 1'b1);
            lit("rr_rotate", gr_rr, rr_seq[i]);
        end

        // Three-beat packet on ch0 holds off ch1.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0011, 4'b0000, 1'b1);
        lit("pkt_beat1", gr_rr, 4'b0001);
        cyc(1'b1, 4'b0011, 4'b0000, 1'b1);
        lit("pkt_beat2", gr_rr, 4'b0001);
        cyc(1'b1, 4'b0011, 4'b0001, 1'b1);
        lit("pkt_beat3", gr_rr, 4'b0001);
        cyc(1'b1, 4'b0011, 4'b0000, 1'b1);
        lit("pkt_next", gr_rr, 4'b0010);

        // Backpressure and source stall while locked on ch2.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0100, 4'b0000, 1'b1);
        cyc(1'b1, 4'b1011, 4'b0000, 1'b0);
        lit("stall_grant", gr_rr, 4'b0100);
        cyc(1'b1, 4'b1011, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1111, 4'b0100, 1'b1);
        lit("stall_resume", gr_rr, 4'b0100);
        cyc(1'b1, 4'b1011, 4'b0000, 1'b1);

        // Fixed priority: index 0 always wins, then index 1.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'b1111, 4'b1111, 1'b1);
            lit("fixed_prio", gr_fx, 4'b0001);
        end
        cyc(1'b1, 4'b1110, 4'b1111, 1'b1);
        lit("fixed_next", gr_fx, 4'b0010);

        // Reset in the middle of a packet abandons the lock.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0010, 4'b0000, 1'b1);
        lit("rst_mid_grant", gr_rr, 4'b0000);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b0);
        lit("rst_mid_after", gr_rr, 4'b0010);

        // Idle cycles leave the pointer where the last packet put it.
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
        cyc(1'b1, 4'b1111, 4'b0000, 1'b0);
        lit("idle_ptr_kept", gr_rr, 4'b0010);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                4'($urandom),
                4'($urandom) & 4'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
